// File: rtl/pet_feeder_dispense_ctrl_pkg.sv
// Shared definitions for the pet feeder dispense controller: state encoding and count widths.
package pet_feeder_dispense_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_FAULT    = 2'd3
    } state_e;

    localparam int PCNT_W   = 8;
    localparam int PTODAY_W = 8;

    // Daily total sticks at all-ones instead of wrapping.
    function automatic logic [PTODAY_W-1:0] sat_inc(input logic [PTODAY_W-1:0] v);
        return (&v) ? v : v + PTODAY_W'(1);
    endfunction

endpackage

// File: rtl/pet_feeder_dispense_ctrl_timer.sv
// Loadable down-counter that stops at zero; serves as the jam timer in RUN and the cooldown timer.
module pet_feeder_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/pet_feeder_dispense_ctrl.sv
// Dispense sequencer: arbitrates scheduled/manual requests, runs the motor for a portion count,
// handles bowl-full, jam timeout and cooldown. PET_FEEDER_DAILY_LIMIT_EN adds a daily cap
// with a midnight clear of the portion total.
module pet_feeder_dispense_ctrl
    import pet_feeder_dispense_ctrl_pkg::*;
#(
    parameter int SCHED_PORTIONS  = 2,
    parameter int MANUAL_PORTIONS = 1,
    parameter int JAM_TIMEOUT     = 1000,
    parameter int COOLDOWN_CYCLES = 500,
    parameter int DAILY_LIMIT     = 8,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                sched_req,
    input  logic                manual_req,
    input  logic                portion_pulse,
    input  logic                bowl_full,
    input  logic                fault_clr,
    input  logic [4:0]          hour,
    input  logic [5:0]          minute,
    output logic                motor_on,
    output logic                busy,
    output logic                done,
    output logic                jam_fault,
    output logic [PTODAY_W-1:0] portions_today
);

    localparam logic [CNT_W-1:0]  JAM_V   = CNT_W'(JAM_TIMEOUT);
    localparam logic [CNT_W-1:0]  COOL_V  = CNT_W'(COOLDOWN_CYCLES);
    localparam logic [PCNT_W-1:0] SCHED_V = PCNT_W'(SCHED_PORTIONS);
    localparam logic [PCNT_W-1:0] MAN_V   = PCNT_W'(MANUAL_PORTIONS);

    state_e              state_q, state_d;
    logic                motor_q, motor_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                jam_q, jam_d;
    logic                pend_q, pend_d;
    logic [PCNT_W-1:0]   tgt_q, tgt_d;
    logic [PCNT_W-1:0]   cnt_q, cnt_d;
    logic [PTODAY_W-1:0] ptoday_q, ptoday_d;

    logic                tmr_load, tmr_zero;
    logic [CNT_W-1:0]    tmr_val;
    logic                req_any, limit_ok, midnight, reached;
    logic [PCNT_W-1:0]   base_tgt, req_tgt, cnt_inc;

    assign req_any  = pend_q | sched_req | manual_req;
    assign base_tgt = (pend_q | sched_req) ? SCHED_V : MAN_V;
    assign cnt_inc  = cnt_q + PCNT_W'(portion_pulse);
    assign reached  = (cnt_inc >= tgt_q);

`ifdef PET_FEEDER_DAILY_LIMIT_EN
    localparam logic [PTODAY_W-1:0] LIMIT_V = PTODAY_W'(DAILY_LIMIT);
    logic [PTODAY_W-1:0] remain;
    logic                mid_now, mid_q;

    assign limit_ok = (ptoday_q < LIMIT_V);
    assign remain   = LIMIT_V - ptoday_q;
    assign req_tgt  = (base_tgt < remain) ? base_tgt : remain;
    assign mid_now  = (hour == 5'd0) && (minute == 6'd0);
    assign midnight = mid_now & ~mid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mid_q <= 1'b0;
        else      mid_q <= mid_now;
    end
`else
    localparam int unused_limit = DAILY_LIMIT;
    logic unused_time;
    assign unused_time = ^{hour, minute};
    assign limit_ok    = 1'b1;
    assign req_tgt     = base_tgt;
    assign midnight    = 1'b0;
`endif

    pet_feeder_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        motor_d  = motor_q;
        done_d   = 1'b0;
        jam_d    = jam_q;
        pend_d   = pend_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        ptoday_d = ptoday_q;
        tmr_load = 1'b0;
        tmr_val  = JAM_V;
        case (state_q)
            ST_IDLE: begin
                if (enable && req_any && limit_ok) begin
                    state_d  = ST_RUN;
                    motor_d  = 1'b1;
                    tgt_d    = req_tgt;
                    cnt_d    = '0;
                    pend_d   = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (sched_req) pend_d = 1'b1;
                if (portion_pulse) begin
                    cnt_d    = cnt_inc;
                    ptoday_d = sat_inc(ptoday_q);
                    tmr_load = 1'b1;
                end
                // enable=0 outranks completion, which outranks a jam
                if (!enable) begin
                    state_d = ST_IDLE;
                    motor_d = 1'b0;
                    pend_d  = 1'b0;
                end else if (reached || bowl_full) begin
                    state_d  = ST_COOLDOWN;
                    motor_d  = 1'b0;
                    done_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = COOL_V;
                end else if (tmr_zero && !portion_pulse) begin
                    state_d = ST_FAULT;
                    motor_d = 1'b0;
                    jam_d   = 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (sched_req) pend_d = 1'b1;
                if (tmr_zero)  state_d = ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_IDLE;
                    jam_d   = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (midnight) ptoday_d = '0;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            motor_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            jam_q    <= 1'b0;
            pend_q   <= 1'b0;
            tgt_q    <= '0;
            cnt_q    <= '0;
            ptoday_q <= '0;
        end else begin
            state_q  <= state_d;
            motor_q  <= motor_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            jam_q    <= jam_d;
            pend_q   <= pend_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            ptoday_q <= ptoday_d;
        end
    end

    assign motor_on       = motor_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign jam_fault      = jam_q;
    assign portions_today = ptoday_q;

endmodule
